// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 byte writer: FSM states, timing defaults, init commands.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_LOAD,
        POP,
        CAPTURE,
        SETUP,
        E_HIGH,
        HOLD,
        EXEC_WAIT,
        IDLE
    } lcd_state_t;

    // Default timing in core cycles at 50 MHz
    localparam int DEF_T_POWERUP = 1000000;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_E       = 12;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_T_SHORT   = 2000;
    localparam int DEF_T_LONG    = 82000;
    localparam int DEF_CNT_W     = 20;

    // 9-bit FIFO word: {rs, data[7:0]}
    localparam int WORD_W = 9;
    localparam int RS_BIT = 8;

    // Init sequence commands
    localparam int         INIT_LEN        = 8;
    localparam logic [7:0] INIT_FUNC_8BIT  = 8'h30;
    localparam logic [7:0] INIT_FUNC_2LINE = 8'h38;
    localparam logic [7:0] INIT_DISP_OFF   = 8'h08;
    localparam logic [7:0] INIT_ENTRY_MODE = 8'h06;
    localparam logic [7:0] INIT_DISP_ON    = 8'h0C;

    // Slow commands; 0x03 decodes as return-home on the controller as well
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init command table lookup: 3-bit index to HD44780 8-bit-mode init command.
// Latency: combinational, zero cycles.
// Backpressure: none.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] cmd
);

    // Fixed power-on sequence: three wake-ups, function set, display off, clear, entry mode, display on
    always_comb begin
        cmd = INIT_DISP_ON;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = INIT_FUNC_8BIT;
            3'd3:             cmd = INIT_FUNC_2LINE;
            3'd4:             cmd = INIT_DISP_OFF;
            3'd5:             cmd = CMD_CLEAR;
            3'd6:             cmd = INIT_ENTRY_MODE;
            default:          cmd = INIT_DISP_ON;
        endcase
    end

endmodule

// File: rtl/lcd_byte_writer.sv
// Runs HD44780 8-bit init, then pops {rs,data} words from the FIFO and strobes them onto the LCD bus.
// Latency: pop to E rise = 2 + T_SETUP cycles; pop-to-pop >= 2 + T_SETUP + T_E + T_HOLD + wait + 1.
// Backpressure: FIFO is only popped from IDLE; words stay in the FIFO while a transfer is in flight.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = DEF_T_POWERUP,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_E       = DEF_T_E,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_SHORT   = DEF_T_SHORT,
    parameter int T_LONG    = DEF_T_LONG,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [7:0]        lcd_data,
    output logic              init_done,
    output logic              busy
);

    // Timer reload values: a state lasting T cycles loads T-1 and leaves when the timer reads 0
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_E       = CNT_W'(T_E - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT   = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG    = CNT_W'(T_LONG - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(INIT_LEN - 1);

    lcd_state_t       state;
    logic [CNT_W-1:0] timer;
    logic [2:0]       init_idx;
    logic [7:0]       rom_cmd;
    logic [CNT_W-1:0] exec_load;

    lcd_init_rom u_init_rom (
        .idx (init_idx),
        .cmd (rom_cmd)
    );

    // Every init entry gets the long wait; afterwards only clear/home do
    assign exec_load = (!init_done || is_long_cmd(lcd_rs, lcd_data)) ? LD_LONG : LD_SHORT;

    // Main sequencer; bus outputs are updated on state transitions so they are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PWR_WAIT;
            timer     <= '0;
            init_idx  <= '0;
            fifo_rd   <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            lcd_rw <= 1'b0;
            case (state)
                // Reset leaves the timer at 0, so power-up counts up rather than down
                PWR_WAIT: begin
                    if (timer == LD_POWERUP) begin
                        timer <= '0;
                        state <= INIT_LOAD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                INIT_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= rom_cmd;
                    timer    <= LD_SETUP;
                    state    <= SETUP;
                end
                POP: begin
                    fifo_rd <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    lcd_rs   <= fifo_data[RS_BIT];
                    lcd_data <= fifo_data[7:0];
                    timer    <= LD_SETUP;
                    state    <= SETUP;
                end
                SETUP: begin
                    if (timer == '0) begin
                        lcd_e <= 1'b1;
                        timer <= LD_E;
                        state <= E_HIGH;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                E_HIGH: begin
                    if (timer == '0) begin
                        lcd_e <= 1'b0;
                        timer <= LD_HOLD;
                        state <= HOLD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        timer <= exec_load;
                        state <= EXEC_WAIT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                EXEC_WAIT: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (init_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (init_idx == LAST_IDX) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                        state    <= INIT_LOAD;
                    end
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                        state   <= POP;
                    end
                end
                default: begin
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench: bus-level reference model of init, FIFO pops and E-strobe timing.
// Latency: n/a.
// Backpressure: bench FIFO model presents data the cycle after fifo_rd.
module tb_lcd_byte_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] fifo_data = 9'h000;
    logic       fifo_empty = 1'b1;
    logic       sel = 1'b0;

    logic       empty1, empty2;
    logic       rd1, rs1, rw1, e1, done1, busy1;
    logic       rd2, rs2, rw2, e2, done2, busy2;
    logic [7:0] data1, data2;

    logic       m_rd, m_rs, m_rw, m_e, m_done, m_busy;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    assign empty1 = sel ? 1'b1 : fifo_empty;
    assign empty2 = sel ? fifo_empty : 1'b1;
    assign m_rd   = sel ? rd2   : rd1;
    assign m_rs   = sel ? rs2   : rs1;
    assign m_rw   = sel ? rw2   : rw1;
    assign m_e    = sel ? e2    : e1;
    assign m_data = sel ? data2 : data1;
    assign m_done = sel ? done2 : done1;
    assign m_busy = sel ? busy2 : busy1;

    lcd_byte_writer #(
        .T_POWERUP(10), .T_SETUP(1), .T_E(3), .T_HOLD(1), .T_SHORT(5), .T_LONG(20), .CNT_W(20)
    ) u_dut_fast (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(empty1),
        .fifo_rd(rd1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_e(e1), .lcd_data(data1),
        .init_done(done1), .busy(busy1)
    );

    // Default bus timing; power-up and long wait shortened so init stays brief
    lcd_byte_writer #(
        .T_POWERUP(10), .T_SETUP(2), .T_E(12), .T_HOLD(2), .T_SHORT(2000), .T_LONG(20), .CNT_W(20)
    ) u_dut_dflt (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(empty2),
        .fifo_rd(rd2), .lcd_rs(rs2), .lcd_rw(rw2), .lcd_e(e2), .lcd_data(data2),
        .init_done(done2), .busy(busy2)
    );

    int vectors = 0;
    int errs = 0;

    // Timing of the DUT currently observed
    int tp, ts, te, th, tsh, tl;

    // Reference model state
    logic [7:0] init_tab [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    logic [8:0] exp_q [$];
    logic [8:0] fq [$];
    int         pop_log [$];
    int         t, n_pulse, rise_t, fall_t, chg_t, pop_t, last_wait;
    logic       prev_e, prev_busy, pop_pending;
    logic [8:0] prev_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input logic [8:0] w, input logic in_init);
        if (in_init || (!w[8] && w[7:0] >= 8'h01 && w[7:0] <= 8'h03)) return tl;
        return tsh;
    endfunction

    task automatic push(input logic [8:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, check against the model, run the FIFO model
    task automatic step();
        logic [8:0] bus;
        logic [8:0] w;
        logic       exp_rd;
        @(negedge clk);
        t++;
        bus    = {m_rs, m_data};
        exp_rd = !prev_busy && !fifo_empty;
        chk("fifo_rd", 32'(m_rd), 32'(exp_rd));
        chk("init_done", 32'(m_done), 32'(t >= tp + 8 * (1 + ts + te + th + tl)));
        if (prev_busy && !m_busy) chk("idle_entry_t", t, fall_t + th + last_wait);
        if (!prev_busy && m_busy) chk("busy_with_pop", 32'(m_rd), 32'd1);
        if (m_e && !prev_e) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
                w = bus;
            end else begin
                w = exp_q.pop_front();
            end
            chk("bus_word", 32'(bus), 32'(w));
            chk("lcd_rw", 32'(m_rw), 32'd0);
            chk("setup_cycles", 32'((t - chg_t) >= ts), 32'd1);
            if (n_pulse < 8) chk("init_rise_t", t, tp + ts + 1 + n_pulse * (1 + ts + te + th + tl));
            else             chk("pop_to_rise_t", t, pop_t + 2 + ts);
            last_wait = wait_of(w, n_pulse < 8);
            rise_t = t;
            n_pulse++;
        end
        if (m_e && prev_e) chk("bus_stable_e_high", 32'(bus), 32'(prev_bus));
        if (!m_e && prev_e) begin
            chk("e_width", t - rise_t, te);
            fall_t = t;
        end
        if (bus !== prev_bus) begin
            if (!m_e) chk("hold_window", 32'((t - fall_t) >= (th + last_wait)), 32'd1);
            chg_t = t;
        end
        // FIFO model: data appears the cycle after the pop strobe
        if (pop_pending) begin
            fifo_data   = fq.pop_front();
            fifo_empty  = (fq.size() == 0);
            pop_pending = 1'b0;
        end
        if (m_rd) begin
            chk("pop_nonempty", 32'(fq.size() > 0), 32'd1);
            pop_pending = (fq.size() > 0);
            pop_t = t;
            pop_log.push_back(t);
        end
        prev_e    = m_e;
        prev_busy = m_busy;
        prev_bus  = bus;
    endtask

    // Assert reset at a falling edge, check outputs drop immediately, release and rearm the model
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_e"},    32'(m_e),    32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_rs"},   32'(m_rs),   32'd0);
        chk({tag, "_done"}, 32'(m_done), 32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
        chk({tag, "_rd"},   32'(m_rd),   32'd0);
        chk({tag, "_rw"},   32'(m_rw),   32'd0);
        repeat (3) @(negedge clk);
        reset       = 1'b0;
        fq.delete();
        exp_q.delete();
        pop_log.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, init_tab[i]});
        fifo_empty  = 1'b1;
        pop_pending = 1'b0;
        t = 0; n_pulse = 0; rise_t = 0; fall_t = -100000; chg_t = 0; pop_t = 0; last_wait = 0;
        prev_e = 1'b0; prev_busy = 1'b1; prev_bus = 9'h000;
    endtask

    task automatic drain(input string tag, input int bound);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && !pop_pending && !m_busy) && k < bound) begin
            step();
            k++;
        end
        chk({tag, "_completes"}, 32'(k < bound), 32'd1);
    endtask

    task automatic set_fast();
        tp = 10; ts = 1; te = 3; th = 1; tsh = 5; tl = 20;
    endtask

    initial begin
        int k, base, gap;
        logic [8:0] w;
        set_fast();
        sel = 1'b0;
        #2;
        do_reset("rst_initial");

        // Init sequence with the FIFO empty
        drain("init", 1000);
        chk("init_pulse_count", n_pulse, 8);
        chk("init_no_pops", pop_log.size(), 0);

        // Single data word
        push({1'b1, 8'h41});
        drain("single_word", 200);

        // Clear command followed by data: long then short wait, second pop right after IDLE
        pop_log.delete();
        push({1'b0, 8'h01});
        push({1'b1, 8'h42});
        drain("clear_then_data", 300);
        if (pop_log.size() == 2) chk("long_pop_spacing", pop_log[1] - pop_log[0], 2 + ts + te + th + tl + 1);
        else chk("clear_then_data_pops", pop_log.size(), 2);

        // Four data words queued: back-to-back pops at minimum spacing
        pop_log.delete();
        for (int i = 0; i < 4; i++) push({1'b1, 8'($urandom_range(0, 255))});
        drain("four_words", 400);
        if (pop_log.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("short_pop_spacing", pop_log[i] - pop_log[i-1], 2 + ts + te + th + tsh + 1);
        end else begin
            chk("four_words_pops", pop_log.size(), 4);
        end

        // Random words at random gaps, including slow commands
        for (int i = 0; i < 24; i++) begin
            w[8] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) w[7:0] = 8'($urandom_range(1, 3));
            else                           w[7:0] = 8'($urandom_range(0, 255));
            push(w);
            gap = $urandom_range(0, 30);
            for (int j = 0; j < gap; j++) step();
        end
        drain("random_words", 2000);

        // Reset while E is high on the second queued word
        base = n_pulse;
        for (int i = 0; i < 3; i++) push({1'b1, 8'h50 + 8'(i)});
        k = 0;
        while (!(n_pulse == base + 2 && m_e) && k < 400) begin
            step();
            k++;
        end
        chk("reach_second_word", 32'(k < 400), 32'd1);
        do_reset("rst_mid_e");
        drain("reinit", 1000);
        chk("reinit_pulse_count", n_pulse, 8);
        push({1'b1, 8'h5A});
        drain("after_reinit", 200);

        // Default bus timing on the second instance
        sel = 1'b1;
        tp = 10; ts = 2; te = 12; th = 2; tsh = 2000; tl = 20;
        do_reset("rst_dflt");
        drain("dflt_init", 2000);
        pop_log.delete();
        push({1'b1, 8'h61});
        push({1'b1, 8'h62});
        drain("dflt_words", 6000);
        if (pop_log.size() == 2) chk("dflt_pop_spacing", pop_log[1] - pop_log[0], 2 + 2 + 12 + 2 + 2000 + 1);
        else chk("dflt_pops", pop_log.size(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
